// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths, master FSM states and response codes.
package apb_pkg;

    localparam int APB_ADDR_WIDTH = 32;
    localparam int APB_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_e;

    localparam logic RSP_OKAY        = 1'b0;
    localparam logic RSP_ERR_TIMEOUT = 1'b1;

endpackage

// File: rtl/apb_cmd_master_if.sv
// Command stream, response stream and APB bus for apb_cmd_master.
interface apb_cmd_master_if
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH = APB_DATA_WIDTH
);

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic                  cmd_write;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    logic [ADDR_WIDTH-1:0] PADDR;
    logic                  PWRITE;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic                  PSEL;
    logic                  PENABLE;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;

    modport master (
        input  cmd_valid, cmd_addr, cmd_write, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output PADDR, PWRITE, PWDATA, PSEL, PENABLE,
        input  PRDATA, PREADY
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_write, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  PADDR, PWRITE, PWDATA, PSEL, PENABLE,
        output PRDATA, PREADY
    );

endinterface

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles with PREADY low; flags the last allowed wait cycle.
module apb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int LIMIT = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (TIMEOUT != 0) && (cnt_q == CW'(LIMIT));

endmodule

// File: rtl/apb_cmd_master.sv
// Turns a valid/ready command stream into APB transfers, one response each,
// with an optional wait-state timeout that aborts the transfer with an error.
module apb_cmd_master
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH = APB_DATA_WIDTH,
    parameter int TIMEOUT    = 16
) (
    input  logic                PCLK,
    input  logic                PRESET_N,
    apb_cmd_master_if.master    bus
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;

    logic tmr_clr;
    logic tmr_en;
    logic tmr_expire;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk    (PCLK),
        .rst_n  (PRESET_N),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .expire (tmr_expire)
    );

    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        tmr_clr     = 1'b0;
        tmr_en      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    paddr_d  = bus.cmd_addr;
                    pwrite_d = bus.cmd_write;
                    pwdata_d = bus.cmd_wdata;
                    tmr_clr  = 1'b1;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                tmr_en = !bus.PREADY;
                // A late PREADY in the expiry cycle still completes normally
                if (bus.PREADY) begin
                    rsp_rdata_d = pwrite_q ? '0 : bus.PRDATA;
                    rsp_err_d   = RSP_OKAY;
                    state_d     = RESP;
                end else if (tmr_expire) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = RSP_ERR_TIMEOUT;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Bus strobes follow the next state so they come straight from flops
        psel_d      = (state_d == SETUP) || (state_d == ACCESS);
        penable_d   = (state_d == ACCESS);
        rsp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge PCLK or negedge PRESET_N) begin
        if (!PRESET_N) begin
            state_q     <= IDLE;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench for apb_cmd_master with a behavioural APB slave.
module tb_apb_cmd_master;

    localparam int TIMEOUT = 16;

    logic clk;
    logic rst_n;

    apb_cmd_master_if bus ();

    apb_cmd_master #(
        .TIMEOUT (TIMEOUT)
    ) dut (
        .PCLK     (clk),
        .PRESET_N (rst_n),
        .bus      (bus.master)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int viol   = 0;

    int          plan_waits = 0;
    logic [31:0] plan_rdata = '0;
    int          acc_cnt    = 0;
    logic        junk_rdy   = 1'b0;
    logic [31:0] junk_data  = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Slave: PREADY rises on ACCESS cycle plan_waits+1; junk outside ACCESS
    always @(posedge clk) begin
        junk_rdy  <= 1'($urandom);
        junk_data <= $urandom;
        if (bus.PSEL && bus.PENABLE) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    assign bus.PREADY = (bus.PSEL && bus.PENABLE) ? (acc_cnt == plan_waits) : junk_rdy;
    assign bus.PRDATA = (bus.PSEL && bus.PENABLE) ? plan_rdata : junk_data;

    always @(negedge clk) if (bus.PENABLE && !bus.PSEL) viol <= viol + 1;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // One command: model gives latency, error and data from the wait plan
    task automatic run_cmd(input logic [31:0] a, input logic w,
                           input logic [31:0] wd, input int waits,
                           input logic [31:0] rd, input int hold);
        int          lat;
        logic        err;
        logic [31:0] exp_d;
        int          k;
        int          bad_k;
        bit          hold_bad;
        lat   = 3 + ((waits < TIMEOUT) ? waits : TIMEOUT - 1);
        err   = (waits >= TIMEOUT);
        exp_d = (w || err) ? 32'h0 : rd;
        plan_waits = waits;
        plan_rdata = rd;
        bus.cmd_addr  = a;
        bus.cmd_write = w;
        bus.cmd_wdata = wd;
        bus.cmd_valid = 1'b1;
        bus.rsp_ready = (hold == 0);
        @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_ready_idle: got %b want 1", bus.cmd_ready);
        end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = $urandom;
        bus.cmd_wdata = $urandom;
        bus.cmd_write = 1'($urandom);
        k = 1;
        bad_k = -1;
        while (k <= lat + 5) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) break;
            if (bad_k < 0 && !(bus.PSEL === 1'b1 && bus.PENABLE === (k >= 2) &&
                bus.PADDR === a && bus.PWRITE === w && bus.PWDATA === wd &&
                bus.cmd_ready === 1'b0))
                bad_k = k;
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (bad_k >= 0) begin
            errors++;
            $display("FAIL bus_phase: cycle %0d psel=%b penable=%b paddr=%h want psel=1 paddr=%h",
                     bad_k, bus.PSEL, bus.PENABLE, bus.PADDR, a);
        end
        checks++;
        if (k !== lat) begin
            errors++;
            $display("FAIL latency: got %0d want %0d", k, lat);
        end
        checks++;
        if (bus.rsp_rdata !== exp_d || bus.rsp_err !== err) begin
            errors++;
            $display("FAIL rsp_data: got %h err=%b want %h err=%b",
                     bus.rsp_rdata, bus.rsp_err, exp_d, err);
        end
        checks++;
        if (bus.PSEL !== 1'b0 || bus.PENABLE !== 1'b0) begin
            errors++;
            $display("FAIL resp_bus_idle: psel=%b penable=%b want 0 0",
                     bus.PSEL, bus.PENABLE);
        end
        hold_bad = 1'b0;
        if (hold > 0) bus.cmd_valid = 1'b1;
        for (int h = 1; h <= hold; h++) begin
            @(posedge clk); #1;
            if (h == hold) begin
                bus.rsp_ready = 1'b1;
                bus.cmd_valid = 1'b0;
            end
            @(negedge clk);
            if (!(bus.rsp_valid === 1'b1 && bus.rsp_rdata === exp_d &&
                  bus.rsp_err === err && bus.cmd_ready === 1'b0 &&
                  bus.PSEL === 1'b0))
                hold_bad = 1'b1;
        end
        if (hold > 0) begin
            checks++;
            if (hold_bad) begin
                errors++;
                $display("FAIL backpressure: rsp_valid=%b rdata=%h cmd_ready=%b psel=%b want 1 %h 0 0",
                         bus.rsp_valid, bus.rsp_rdata, bus.cmd_ready, bus.PSEL, exp_d);
            end
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0 ||
            bus.rsp_rdata !== 32'h0 || bus.rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL %s_rsp: ready=%b valid=%b rdata=%h err=%b want 1 0 0 0", tag,
                     bus.cmd_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
        end
        checks++;
        if (bus.PADDR !== 32'h0 || bus.PWRITE !== 1'b0 || bus.PWDATA !== 32'h0 ||
            bus.PSEL !== 1'b0 || bus.PENABLE !== 1'b0) begin
            errors++;
            $display("FAIL %s_bus: paddr=%h pwrite=%b pwdata=%h psel=%b pen=%b want zeros", tag,
                     bus.PADDR, bus.PWRITE, bus.PWDATA, bus.PSEL, bus.PENABLE);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_write = 1'b0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;
        #2;
        check_reset_vals("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_zero_wait_write;
        run_cmd(32'h10, 1'b1, 32'hDEAD_BEEF, 0, 32'h1234_5678, 0);
    endtask

    task automatic test_read_waits;
        run_cmd(32'h44, 1'b0, 32'h0BAD_F00D, 3, 32'hA5A5_0001, 0);
    endtask

    task automatic test_timeout;
        run_cmd(32'h80, 1'b0, 32'h0, 100, 32'hFFFF_FFFF, 0);
        run_cmd(32'h84, 1'b1, 32'h5555_AAAA, 100, 32'h0, 0);
        run_cmd(32'h88, 1'b0, 32'h0, TIMEOUT - 1, 32'hC0DE_0001, 0);
    endtask

    task automatic test_backpressure;
        run_cmd(32'h200, 1'b0, 32'h0, 1, 32'h7777_1111, 5);
        run_cmd(32'h204, 1'b1, 32'h3333_4444, 0, 32'h0, 0);
    endtask

    task automatic test_back_to_back;
        int start;
        int span;
        start = cyc;
        for (int i = 0; i < 8; i++)
            run_cmd(32'h1000 + 32'(4 * i), 1'(i & 1), 32'h100 + 32'(i), 0,
                    32'hB000_0000 + 32'(i), 0);
        span = cyc - start;
        checks++;
        if (span !== 32) begin
            errors++;
            $display("FAIL b2b_cycles: got %0d want 32", span);
        end
    endtask

    task automatic test_reset_mid;
        bit stray;
        plan_waits = 50;
        bus.cmd_addr  = 32'h300;
        bus.cmd_write = 1'b0;
        bus.cmd_wdata = 32'h9;
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_reset_vals("reset_mid");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0 || bus.PSEL !== 1'b0) stray = 1'b1;
        end
        checks++;
        if (stray) begin
            errors++;
            $display("FAIL reset_drop: rsp_valid=%b psel=%b want 0 0", bus.rsp_valid, bus.PSEL);
        end
        @(posedge clk); #1;
        run_cmd(32'h304, 1'b0, 32'h0, 2, 32'h600D_0001, 0);
    endtask

    task automatic test_random;
        int w;
        for (int i = 0; i < 24; i++) begin
            w = ($urandom_range(0, 7) == 0) ? 40 : int'($urandom_range(0, 4));
            run_cmd($urandom, 1'($urandom), $urandom, w, $urandom,
                    int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait_write();
        test_read_waits();
        test_timeout();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        checks++;
        if (viol !== 0) begin
            errors++;
            $display("FAIL penable_without_psel: got %0d cycles want 0", viol);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_cmd_master.md
# apb_cmd_master

Converts a simple valid/ready command stream into APB transfers on the team's APB interface and returns one response per command. Sits directly upstream of the APB bus as the only master driving PADDR/PSEL/PENABLE/PWRITE/PWDATA. Sequences the IDLE/SETUP/ACCESS phases, honours PREADY wait states, and aborts with an error after a programmable wait-state timeout.

## Interface
- ADDR_WIDTH, default `ADDR_WIDTH` from the shared APB defines header (32): PADDR/cmd_addr width
- DATA_WIDTH, default `DATA_WIDTH` from the shared APB defines header (32): data width
- TIMEOUT, default 16: max ACCESS cycles with PREADY low before abort; 0 disables the timeout
- PCLK  in  1  clock; all logic on posedge
- PRESET_N  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  block accepts command
- cmd_addr  in  ADDR_WIDTH  target address
- cmd_write  in  1  1 = write, 0 = read
- cmd_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes and errors)
- rsp_err  out  1  transfer aborted by timeout
- PADDR  out  ADDR_WIDTH; PWRITE  out  1; PWDATA  out  DATA_WIDTH; PSEL  out  1; PENABLE  out  1
- PRDATA  in  DATA_WIDTH; PREADY  in  1

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. Reset state IDLE.
- IDLE: cmd_ready=1. On cmd_valid & cmd_ready, latch addr/write/wdata into PADDR/PWRITE/PWDATA, go SETUP.
- SETUP: PSEL=1, PENABLE=0, cmd_ready=0. Unconditionally go ACCESS.
- ACCESS: PSEL=1, PENABLE=1. Wait counter increments each ACCESS cycle with PREADY=0.
  - PREADY=1: capture PRDATA into rsp_rdata if read (0 if write), rsp_err=0, go RESP.
  - PREADY=0 and counter == TIMEOUT-1 (TIMEOUT≠0): rsp_rdata=0, rsp_err=1, go RESP.
  - PREADY=1 in the timeout cycle wins: normal completion, no error.
- RESP: PSEL=0, PENABLE=0, rsp_valid=1; rsp_rdata/rsp_err stable until rsp_ready. On rsp_valid & rsp_ready go IDLE.
- PADDR/PWRITE/PWDATA held constant from SETUP through end of ACCESS; hold last value in IDLE/RESP (no toggling when PSEL=0).
- Never PENABLE=1 with PSEL=0. PSEL never deasserts between SETUP and ACCESS.
- One outstanding transfer; no command accepted until the response is consumed.
- Wait counter width $clog2(TIMEOUT+1) (min 1); cleared on entering SETUP.

## Timing
- All outputs registered except cmd_ready (decoded from state register, no combinational path from inputs).
- Reset values: cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, PADDR=0, PWRITE=0, PWDATA=0, PSEL=0, PENABLE=0.
- Cycle 0 handshake; cycle 1 SETUP; cycle 2 ACCESS; PREADY=1 in cycle 2 → rsp_valid=1 in cycle 3. Latency 3 cycles + 1 per wait state.
- Back-to-back with rsp_ready tied 1: one transfer per 4 cycles (IDLE, SETUP, ACCESS, RESP).
- Timeout: TIMEOUT consecutive ACCESS cycles with PREADY=0 → rsp_valid (err) in next cycle, PSEL/PENABLE low that same cycle.
- PREADY/PRDATA ignored outside ACCESS.
- Reset asserted mid-transfer: all outputs to reset values immediately (asynchronous), transfer dropped, no response generated.

## Structure
- Shared package apb_pkg: FSM state enum (IDLE/SETUP/ACCESS/RESP), response error code constant.
- Widths taken from the shared APB defines header; no local width constants.
- Optional sub-module apb_wait_timer (counter, clear, enable, expire at TIMEOUT-1); everything else in the single top module.

## Test plan
- Zero-wait write: cmd addr=0x10, wdata=0xDEADBEEF, PREADY=1 → PSEL rises cycle 1, PENABLE cycle 2, rsp_valid cycle 3, rsp_err=0, rsp_rdata=0.
- Read with 3 wait states: PREADY high on 4th ACCESS cycle, PRDATA=0xA5A5_0001 → rsp_rdata=0xA5A5_0001 in cycle 6; PADDR/PWDATA/PSEL stable throughout.
- Timeout, TIMEOUT=16, PREADY held 0 → exactly 16 ACCESS cycles, then rsp_err=1, rsp_rdata=0, PSEL=PENABLE=0.
- Response backpressure: rsp_ready=0 for 5 cycles → rsp_valid/rsp_rdata held, cmd_ready=0, PSEL=0; new command accepted only after rsp_ready.
- Back-to-back 8 mixed commands, rsp_ready=1, PREADY=1 → 8 in-order responses in 32 cycles, no PENABLE without PSEL.
- PRESET_N pulled low during ACCESS → outputs at reset values same cycle, no rsp_valid; next command after reset completes normally.
